// File: rtl/ttt_nk_engine_if.sv
// Move/status/read-port bundle for ttt_nk_engine.
// Optional undo_req signal exists only when TTT_UNDO_EN is defined.
interface ttt_nk_engine_if #(
    parameter int BOARD_N     = 3,
    parameter int NUM_PLAYERS = 2
);
    localparam int XY_W  = ($clog2(BOARD_N) > 1) ? $clog2(BOARD_N) : 1;
    localparam int CW    = $clog2(NUM_PLAYERS + 1);
    localparam int CNT_W = $clog2(BOARD_N * BOARD_N + 1);

    // Handshake: a move transfers on a clk edge where move_valid && move_ready;
    // move_x/move_y/move_player are only sampled on that edge.
    logic             move_valid;
    logic             move_ready;
    logic [XY_W-1:0]  move_x;
    logic [XY_W-1:0]  move_y;
    logic [CW-1:0]    move_player;
    logic             move_ack;
    logic             move_err;
    logic [1:0]       err_code;
    logic [CW-1:0]    turn_player;
    logic [CNT_W-1:0] move_cnt;
    logic [CW-1:0]    winner;
    logic             stop_game;
    logic [XY_W-1:0]  rd_x;
    logic [XY_W-1:0]  rd_y;
    logic [CW-1:0]    rd_cell;
    logic             dbg_state;
`ifdef TTT_UNDO_EN
    logic             undo_req;
`endif

    modport master (
`ifdef TTT_UNDO_EN
        output undo_req,
`endif
        output move_valid, move_x, move_y, move_player, rd_x, rd_y,
        input  move_ready, move_ack, move_err, err_code, turn_player,
        input  move_cnt, winner, stop_game, rd_cell, dbg_state
    );

    modport slave (
`ifdef TTT_UNDO_EN
        input  undo_req,
`endif
        input  move_valid, move_x, move_y, move_player, rd_x, rd_y,
        output move_ready, move_ack, move_err, err_code, turn_player,
        output move_cnt, winner, stop_game, rd_cell, dbg_state
    );
endinterface

// File: rtl/ttt_nk_engine.sv
// N x N, K-in-a-row turn-based game engine with move validation and incremental win detection.
// Optional one-level undo of the last valid move when TTT_UNDO_EN is defined.
module ttt_nk_engine #(
    parameter int BOARD_N     = 3,
    parameter int WIN_K       = 3,
    parameter int NUM_PLAYERS = 2
) (
    input logic          clk,
    input logic          reset,
    ttt_nk_engine_if.slave bus
);
    localparam int XY_W  = ($clog2(BOARD_N) > 1) ? $clog2(BOARD_N) : 1;
    localparam int CW    = $clog2(NUM_PLAYERS + 1);
    localparam int CNT_W = $clog2(BOARD_N * BOARD_N + 1);
    localparam int CELLS = BOARD_N * BOARD_N;
    localparam int IDX_W = $clog2(CELLS);
    localparam logic [CW-1:0] EMPTY = '1;

    typedef enum logic {ST_IDLE = 1'b0, ST_CHECK = 1'b1} state_t;

    state_t           r_state, w_next;
    logic [CW-1:0]    r_board [CELLS];
    logic [CW-1:0]    r_turn, r_winner, r_pp;
    logic [CNT_W-1:0] r_cnt;
    logic             r_stop, r_ok, r_err;
    logic [1:0]       r_code;
    logic [XY_W-1:0]  r_px, r_py;
    logic             w_hs, w_in_range, w_win, w_full, w_undo_take;
    logic [IDX_W-1:0] w_idx;
`ifdef TTT_UNDO_EN
    logic [IDX_W-1:0] r_lidx;
    logic [CW-1:0]    r_lp;
    logic             r_undone;

    assign w_undo_take = (r_state == ST_IDLE) && bus.undo_req && (r_cnt != '0) && !r_undone;
`else
    assign w_undo_take = 1'b0;
`endif

    assign w_hs       = bus.move_valid && bus.move_ready;
    assign w_in_range = (int'(bus.move_x) < BOARD_N) && (int'(bus.move_y) < BOARD_N);
    assign w_idx      = IDX_W'(int'(bus.move_y) * BOARD_N + int'(bus.move_x));
    assign w_full     = (int'(r_cnt) + 1 == CELLS);

    always_ff @(posedge clk) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_hs) w_next = ST_CHECK;
            ST_CHECK: w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.move_ready = (r_state == ST_IDLE) && !r_stop && !w_undo_take;
        bus.move_ack   = (r_state == ST_CHECK) && r_ok;
        bus.move_err   = (r_state == ST_CHECK) && r_err;
        bus.dbg_state  = r_state;
    end

    // Walk outward from the placed stone in both senses of each direction; a run stops
    // at the first foreign/empty cell or the board edge.
    always_comb begin
        int   dx, dy, run, nx, ny;
        logic alive;
        w_win = 1'b0;
        dx = 0; dy = 0; run = 0; nx = 0; ny = 0; alive = 1'b0;
        for (int d = 0; d < 4; d++) begin
            dx  = (d == 1) ? 0 : 1;
            dy  = (d == 0) ? 0 : ((d == 3) ? -1 : 1);
            run = 1;
            for (int sg = -1; sg <= 1; sg += 2) begin
                alive = 1'b1;
                for (int s = 1; s < WIN_K; s++) begin
                    nx = int'(r_px) + sg * s * dx;
                    ny = int'(r_py) + sg * s * dy;
                    if (alive && nx >= 0 && nx < BOARD_N && ny >= 0 && ny < BOARD_N &&
                        r_board[IDX_W'(ny * BOARD_N + nx)] == r_pp)
                        run = run + 1;
                    else
                        alive = 1'b0;
                end
            end
            if (run >= WIN_K) w_win = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < CELLS; i++) r_board[i] <= EMPTY;
            r_turn   <= '0;
            r_cnt    <= '0;
            r_winner <= EMPTY;
            r_stop   <= 1'b0;
            r_ok     <= 1'b0;
            r_err    <= 1'b0;
            r_code   <= 2'b00;
            r_px     <= '0;
            r_py     <= '0;
            r_pp     <= '0;
`ifdef TTT_UNDO_EN
            r_lidx   <= '0;
            r_lp     <= '0;
            r_undone <= 1'b0;
`endif
        end else begin
            if (r_state == ST_CHECK) begin
                if (r_ok) begin
                    r_cnt  <= r_cnt + CNT_W'(1);
                    r_turn <= (r_turn == CW'(NUM_PLAYERS - 1)) ? '0 : r_turn + CW'(1);
                    if (w_win) begin
                        r_winner <= r_pp;
                        r_stop   <= 1'b1;
                    end else if (w_full) begin
                        r_winner <= EMPTY;
                        r_stop   <= 1'b1;
                    end
                end
            end
`ifdef TTT_UNDO_EN
            else if (w_undo_take) begin
                r_board[r_lidx] <= EMPTY;
                r_cnt    <= r_cnt - CNT_W'(1);
                r_turn   <= r_lp;
                r_winner <= EMPTY;
                r_stop   <= 1'b0;
                r_undone <= 1'b1;
            end
`endif
            else if (w_hs) begin
                r_px  <= bus.move_x;
                r_py  <= bus.move_y;
                r_pp  <= bus.move_player;
                r_ok  <= 1'b0;
                r_err <= 1'b1;
                if (bus.move_player != r_turn)      r_code <= 2'b11;
                else if (!w_in_range)               r_code <= 2'b01;
                else if (r_board[w_idx] != EMPTY)   r_code <= 2'b10;
                else begin
                    r_code         <= 2'b00;
                    r_ok           <= 1'b1;
                    r_err          <= 1'b0;
                    r_board[w_idx] <= bus.move_player;
`ifdef TTT_UNDO_EN
                    r_lidx   <= w_idx;
                    r_lp     <= bus.move_player;
                    r_undone <= 1'b0;
`endif
                end
            end
        end
    end

    always_comb begin
        bus.rd_cell = EMPTY;
        if (int'(bus.rd_x) < BOARD_N && int'(bus.rd_y) < BOARD_N)
            bus.rd_cell = r_board[IDX_W'(int'(bus.rd_y) * BOARD_N + int'(bus.rd_x))];
    end

    assign bus.err_code    = r_code;
    assign bus.turn_player = r_turn;
    assign bus.move_cnt    = r_cnt;
    assign bus.winner      = r_winner;
    assign bus.stop_game   = r_stop;
endmodule
